// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter: round-robin sharing of one combinational posit adder
// among NREQ valid/ready requesters, with an ID-tagged response channel.
module posit_add_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    input  logic [N-1:0]      add_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam int unsigned CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    rr_ptr_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [N-1:0]      op1_nx;
    logic [N-1:0]      op2_nx;
    logic [N-1:0]      data_nx;
    logic [IDW-1:0]    id_nx;
    logic              vld_nx;

    logic [2*NREQ-1:0] rot_valid;
    logic [IDW-1:0]    grant;
    logic              grant_vld;
    int unsigned       scan_idx;
    logic [N-1:0]      sel_in1;
    logic [N-1:0]      sel_in2;

    // Round-robin search: first valid lane at or above rr_ptr, wrapping modulo NREQ
    always_comb begin
        rot_valid = {req_valid, req_valid} >> rr_ptr;
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_vld && rot_valid[k]) begin
                grant_vld = 1'b1;
                scan_idx  = 32'(rr_ptr) + k;
                if (scan_idx >= NREQ) begin
                    scan_idx = scan_idx - NREQ;
                end
                grant = IDW'(scan_idx);
            end
        end
    end

    // Operand mux for the granted lane
    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(grant) == k) begin
                sel_in1 = req_in1[k*N +: N];
                sel_in2 = req_in2[k*N +: N];
            end
        end
    end

    // Next-state and next-value logic; req_ready is the only combinational output
    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        cnt_nx    = cnt;
        op1_nx    = add_in1;
        op2_nx    = add_in2;
        data_nx   = rsp_data;
        id_nx     = rsp_id;
        vld_nx    = rsp_valid;
        req_ready = '0;

        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready = NREQ'(1) << grant;
                    op1_nx    = sel_in1;
                    op2_nx    = sel_in2;
                    id_nx     = grant;
                    cnt_nx    = CNT_INIT;
                    if (32'(grant) == NREQ - 1) begin
                        rr_ptr_nx = '0;
                    end else begin
                        rr_ptr_nx = grant + IDW'(1);
                    end
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    data_nx  = add_out;
                    vld_nx   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    vld_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            add_in1   <= '0;
            add_in2   <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            cnt       <= cnt_nx;
            add_in1   <= op1_nx;
            add_in2   <= op2_nx;
            rsp_data  <= data_nx;
            rsp_id    <= id_nx;
            rsp_valid <= vld_nx;
        end
    end

    // Busy whenever an operation owns the adder or the response channel
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_posit_add_arbiter.sv
// tb_posit_add_arbiter: directed checks of arbitration, latency, backpressure
// and reset for ADD_LAT=1 (u0) and ADD_LAT=3 (u3) instances.
module tb_posit_add_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic [7:0]  add_in1;
    logic [7:0]  add_in2;
    logic [7:0]  add_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    logic        l3_reset;
    logic [3:0]  l3_req_valid;
    logic [3:0]  l3_req_ready;
    logic [31:0] l3_req_in1;
    logic [31:0] l3_req_in2;
    logic [7:0]  l3_add_in1;
    logic [7:0]  l3_add_in2;
    logic [7:0]  l3_add_out;
    logic        l3_rsp_valid;
    logic        l3_rsp_ready;
    logic [7:0]  l3_rsp_data;
    logic [1:0]  l3_rsp_id;
    logic        l3_busy;

    int tests;
    int failed;

    // Stand-in for the posit8/es=4 adder on the directed vectors used here
    function automatic logic [7:0] stub_add(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h80 || b == 8'h80) return 8'h80;
        if (a == 8'h40 && b == 8'h40) return 8'h42;
        return a + b;
    endfunction

    assign add_out    = stub_add(add_in1, add_in2);
    assign l3_add_out = stub_add(l3_add_in1, l3_add_in2);

    posit_add_arbiter #(.N(8), .NREQ(4), .IDW(2), .ADD_LAT(1)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .add_in1(add_in1), .add_in2(add_in2),
        .add_out(add_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    posit_add_arbiter #(.N(8), .NREQ(4), .IDW(2), .ADD_LAT(3)) u3 (
        .clk(clk), .reset(l3_reset), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_in1(l3_req_in1), .req_in2(l3_req_in2), .add_in1(l3_add_in1), .add_in2(l3_add_in2),
        .add_out(l3_add_out), .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
        .rsp_data(l3_rsp_data), .rsp_id(l3_rsp_id), .busy(l3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset u0 only
    task automatic reset_u0();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // One full transaction on u0; reports timeout instead of hanging
    task automatic do_op(input int lane, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] rdata, output logic [1:0] rid, output bit to);
        int n;
        to = 1'b0;
        @(negedge clk);
        req_in1[lane*8 +: 8] = a;
        req_in2[lane*8 +: 8] = b;
        req_valid = 4'(1 << lane);
        #1;
        n = 0;
        while (req_ready[lane] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) to = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) to = 1'b1;
        rdata = rsp_data;
        rid   = rsp_id;
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin failed++; $display("FAIL reset_rsp: got data %h id %0d expected 00 0", rsp_data, rsp_id); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (add_in1 !== 8'h00 || add_in2 !== 8'h00) begin failed++; $display("FAIL reset_add_in: got %h %h expected 00 00", add_in1, add_in2); end
        tests++; if (l3_busy !== 1'b0 || l3_rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_l3: got busy %b valid %b expected 0 0", l3_busy, l3_rsp_valid); end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_in1[7:0] = 8'h40;
        req_in2[7:0] = 8'h40;
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        tests++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin failed++; $display("FAIL single_wait: got ready %b busy %b expected 0000 1", req_ready, busy); end
        tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
        tests++; if (add_in1 !== 8'h40 || add_in2 !== 8'h40) begin failed++; $display("FAIL single_add_in: got %h %h expected 40 40", add_in1, add_in2); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1) begin failed++; $display("FAIL single_latency: got valid %b expected 1 at T+2", rsp_valid); end
        tests++; if (rsp_data !== 8'h42 || rsp_id !== 2'd0) begin failed++; $display("FAIL single_rsp: got data %h id %0d expected 42 0", rsp_data, rsp_id); end
        tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL single_resp_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL single_done: got valid %b busy %b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5];
        logic [7:0] exp_data [5];
        logic [1:0] got_id [5];
        logic [7:0] got_data [5];
        int got_cyc [5];
        int cnt;
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        reset_u0();
        @(negedge clk);
        req_in1 = {8'h40, 8'h30, 8'h20, 8'h10};
        req_in2 = {8'h04, 8'h03, 8'h02, 8'h01};
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 5; c++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                got_id[cnt] = rsp_id;
                got_data[cnt] = rsp_data;
                got_cyc[cnt] = c;
                cnt++;
            end
            if (cnt < 5) @(negedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (cnt != 5) begin
            failed++; $display("FAIL rr_count: got %0d responses expected 5", cnt);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++; if (got_id[i] !== exp_id[i] || got_data[i] !== exp_data[i]) begin failed++; $display("FAIL rr_order[%0d]: got id %0d data %h expected id %0d data %h", i, got_id[i], got_data[i], exp_id[i], exp_data[i]); end
            end
            for (int i = 1; i < 5; i++) begin
                tests++; if (got_cyc[i] - got_cyc[i-1] != 3) begin failed++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, got_cyc[i] - got_cyc[i-1]); end
            end
        end
        rsp_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_in1[15:8] = 8'h40;
        req_in2[15:8] = 8'h40;
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'b0010) begin failed++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1) begin failed++; $display("FAIL bp_valid: got %b expected 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            tests++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h42 || rsp_id !== 2'd1) begin failed++; $display("FAIL bp_hold[%0d]: got valid %b data %h id %0d expected 1 42 1", i, rsp_valid, rsp_data, rsp_id); end
            tests++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin failed++; $display("FAIL bp_block[%0d]: got busy %b ready %b expected 1 0000", i, busy, req_ready); end
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL bp_release: got valid %b busy %b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_specials();
        logic [7:0] d;
        logic [1:0] id;
        bit to;
        do_op(2, 8'h80, 8'h40, d, id, to);
        tests++; if (to || d !== 8'h80 || id !== 2'd2) begin failed++; $display("FAIL special_nar: got data %h id %0d timeout %0d expected 80 2 0", d, id, to); end
        do_op(3, 8'h00, 8'h00, d, id, to);
        tests++; if (to || d !== 8'h00 || id !== 2'd3) begin failed++; $display("FAIL special_zero: got data %h id %0d timeout %0d expected 00 3 0", d, id, to); end
    endtask

    task automatic test_lat3();
        bit seen;
        @(negedge clk);
        l3_req_in1[23:16] = 8'h40;
        l3_req_in2[23:16] = 8'h40;
        l3_req_valid = 4'b0100;
        #1;
        tests++; if (l3_req_ready !== 4'b0100) begin failed++; $display("FAIL l3_grant: got %b expected 0100", l3_req_ready); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            l3_req_valid = '0;
            #1;
            tests++; if (l3_add_in1 !== 8'h40 || l3_add_in2 !== 8'h40 || l3_rsp_valid !== 1'b0 || l3_busy !== 1'b1) begin failed++; $display("FAIL l3_wait[T+%0d]: got in %h %h valid %b busy %b expected 40 40 0 1", k, l3_add_in1, l3_add_in2, l3_rsp_valid, l3_busy); end
        end
        @(negedge clk);
        #1;
        tests++; if (l3_rsp_valid !== 1'b1 || l3_rsp_data !== 8'h42 || l3_rsp_id !== 2'd2) begin failed++; $display("FAIL l3_rsp: got valid %b data %h id %0d expected 1 42 2", l3_rsp_valid, l3_rsp_data, l3_rsp_id); end
        @(negedge clk);
        l3_rsp_ready = 1'b1;
        #1;
        @(negedge clk);
        l3_rsp_ready = 1'b0;
        #1;
        tests++; if (l3_busy !== 1'b0) begin failed++; $display("FAIL l3_done: got busy %b expected 0", l3_busy); end

        @(negedge clk);
        l3_req_in1[15:8] = 8'h10;
        l3_req_in2[15:8] = 8'h20;
        l3_req_valid = 4'b0010;
        #1;
        tests++; if (l3_req_ready !== 4'b0010) begin failed++; $display("FAIL l3_grant2: got %b expected 0010", l3_req_ready); end
        @(negedge clk);
        l3_req_valid = '0;
        @(negedge clk);
        l3_reset = 1'b1;
        #1;
        tests++; if (l3_rsp_valid !== 1'b0 || l3_rsp_data !== 8'h00 || l3_rsp_id !== 2'd0 || l3_busy !== 1'b0) begin failed++; $display("FAIL l3_reset_rsp: got valid %b data %h id %0d busy %b expected 0 00 0 0", l3_rsp_valid, l3_rsp_data, l3_rsp_id, l3_busy); end
        tests++; if (l3_add_in1 !== 8'h00 || l3_add_in2 !== 8'h00 || l3_req_ready !== 4'b0000) begin failed++; $display("FAIL l3_reset_add: got in %h %h ready %b expected 00 00 0000", l3_add_in1, l3_add_in2, l3_req_ready); end
        @(negedge clk);
        l3_reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (l3_rsp_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin failed++; $display("FAIL l3_discard: got rsp_valid after reset expected none"); end
        @(negedge clk);
        l3_req_valid = 4'b1111;
        #1;
        tests++; if (l3_req_ready !== 4'b0001) begin failed++; $display("FAIL l3_ptr_reset: got %b expected 0001", l3_req_ready); end
        @(negedge clk);
        l3_reset = 1'b1;
        l3_req_valid = '0;
        @(negedge clk);
        l3_reset = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic [1:0] id;
        bit to;
        logic [3:0] grants [2];
        int gcnt;
        int others;
        bit got0;
        reset_u0();
        do_op(2, 8'h01, 8'h02, d, id, to);
        tests++; if (to || d !== 8'h03 || id !== 2'd2) begin failed++; $display("FAIL wrap_setup: got data %h id %0d timeout %0d expected 03 2 0", d, id, to); end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'b1001;
        gcnt = 0;
        for (int c = 0; c < 20 && gcnt < 2; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                grants[gcnt] = req_ready;
                gcnt++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        tests++;
        if (gcnt != 2) begin
            failed++; $display("FAIL wrap_count: got %0d grants expected 2", gcnt);
        end else begin
            tests++; if (grants[0] !== 4'b1000 || grants[1] !== 4'b0001) begin failed++; $display("FAIL wrap_order: got %b then %b expected 1000 then 0001", grants[0], grants[1]); end
        end
        repeat (4) @(negedge clk);

        others = 0;
        got0 = 1'b0;
        for (int c = 0; c < 40 && !got0; c++) begin
            @(negedge clk);
            req_valid = (c % 2 == 0) ? 4'b1111 : 4'b0001;
            #1;
            if (req_ready !== 4'b0000) begin
                if (req_ready[0] === 1'b1) got0 = 1'b1;
                else others++;
            end
        end
        @(negedge clk);
        req_valid = '0;
        tests++; if (!got0 || others > 3) begin failed++; $display("FAIL fairness: got lane0 granted %0d after %0d other grants expected 1 and at most 3", got0, others); end
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b1;
        l3_reset = 1'b1;
        req_valid = '0;
        req_in1 = '0;
        req_in2 = '0;
        rsp_ready = 1'b0;
        l3_req_valid = '0;
        l3_req_in1 = '0;
        l3_req_in2 = '0;
        l3_rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        l3_reset = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_specials();
        test_lat3();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog so a stuck handshake cannot hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
